// File: rtl/iob_cache_be_arbiter.sv
// iob_cache_be_arbiter: round-robin sharing of one native memory port among N_MASTERS masters; define CACHE_ARB_BURST_LOCK_EN to hold the grant across consecutive reads
module iob_cache_be_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BURST_W = 3,
  parameter int MASTER_W = $clog2(N_MASTERS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTERS-1:0]         m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]  m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]  m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [N_MASTERS-1:0]         m_ready,
  output logic                         mem_valid,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_wstrb,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_ready
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [MASTER_W-1:0] grant, grant_n, ptr, ptr_n;
  logic done;
  function automatic logic [MASTER_W-1:0] inc(input logic [MASTER_W-1:0] v);
    return v == MASTER_W'(N_MASTERS - 1) ? '0 : v + 1'b1;
  endfunction
  function automatic logic [MASTER_W-1:0] rr(input logic [N_MASTERS-1:0] v, input logic [MASTER_W-1:0] base);
    logic [MASTER_W-1:0] s;
    s = base;
    for (int k = N_MASTERS - 1; k >= 0; k--)
      if (v[(int'(base) + k) % N_MASTERS]) s = MASTER_W'((int'(base) + k) % N_MASTERS);
    return s;
  endfunction
  assign done = state == BUSY && mem_ready;
  assign mem_valid = state == BUSY;
  assign mem_addr = m_addr[grant*ADDR_W +: ADDR_W];
  assign mem_wdata = m_wdata[grant*DATA_W +: DATA_W];
  assign mem_wstrb = m_wstrb[grant*(DATA_W/8) +: DATA_W/8];
  assign m_ready = done ? N_MASTERS'(1) << grant : '0;
  assign m_rdata = mem_rdata;
`ifdef CACHE_ARB_BURST_LOCK_EN
  logic [BURST_W-1:0] lock_cnt, lock_n;
  logic locked;
  assign locked = lock_cnt != '0;
  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n = ptr;
    lock_n = lock_cnt;
    if (state == IDLE) begin
      if (locked && !m_valid[grant]) begin
        lock_n = '0;
        ptr_n = inc(grant);
      end
      if (locked && m_valid[grant]) state_n = BUSY;
      else if (|m_valid) begin
        state_n = BUSY;
        grant_n = rr(m_valid, locked ? inc(grant) : ptr);
      end
    end else if (mem_ready) begin
      state_n = IDLE;
      lock_n = |mem_wstrb ? '0 : locked ? lock_cnt - 1'b1 : '1;
      ptr_n = lock_n == '0 ? inc(grant) : ptr;
    end
  end
  always_ff @(posedge clk) lock_cnt <= !reset ? '0 : lock_n;
`else
  localparam int unused_burst_w = BURST_W;
  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n = ptr;
    if (state == IDLE) begin
      if (|m_valid) begin
        state_n = BUSY;
        grant_n = rr(m_valid, ptr);
      end
    end else if (mem_ready) begin
      state_n = IDLE;
      ptr_n = inc(grant);
    end
  end
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr <= ptr_n;
    end
endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// tb_iob_cache_be_arbiter: scoreboard bench for the two-master native port arbiter
module tb_iob_cache_be_arbiter;
  logic clk = 0;
  logic reset = 0;
  logic [1:0] m_valid = '0;
  logic [63:0] m_addr, m_wdata;
  logic [7:0] m_wstrb;
  logic [31:0] m_rdata;
  logic [1:0] m_ready;
  logic mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic mem_ready = 0;
  typedef struct {int m; logic [31:0] a; logic [31:0] d; logic [3:0] s;} exp_t;
  exp_t exp_q[$];
  logic [31:0] ma[2], mw[2];
  logic [3:0] ms[2];
  int rem[2];
  int tests = 0, failed = 0;
  int wait_cfg = 0, cnt = 0;
  bit active = 0, prev_done = 0, req_pend = 0;
  iob_cache_be_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .BURST_W(3)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive();
    m_addr = {ma[1], ma[0]};
    m_wdata = {mw[1], mw[0]};
    m_wstrb = {ms[1], ms[0]};
    for (int i = 0; i < 2; i++) m_valid[i] = rem[i] > 0;
  endtask
  task automatic setm(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int n);
    ma[m] = a;
    mw[m] = d;
    ms[m] = s;
    rem[m] = n;
  endtask
  task automatic push(input int m, input int n);
    exp_t e;
    e.m = m;
    e.a = ma[m];
    e.d = mw[m];
    e.s = ms[m];
    repeat (n) exp_q.push_back(e);
  endtask
  task automatic step();
    exp_t e;
    logic done;
    @(negedge clk);
    if (req_pend) check("regrant_latency", mem_valid, 1);
    if (prev_done) check("bubble", mem_valid, 0);
    mem_rdata = $urandom;
    if (mem_valid) begin
      if (!active) begin
        active = 1;
        cnt = wait_cfg;
      end
      mem_ready = cnt == 0;
    end else mem_ready = 1'($urandom_range(0, 1));
    #1;
    done = 0;
    if (!mem_valid) check("m_ready_idle", m_ready, 0);
    else if (exp_q.size() == 0) check("spurious_grant", mem_valid, 0);
    else begin
      e = exp_q[0];
      check("mem_addr", mem_addr, e.a);
      check("mem_wdata", mem_wdata, e.d);
      check("mem_wstrb", mem_wstrb, e.s);
      if (mem_ready) begin
        check("m_ready", m_ready, 64'(1) << e.m);
        check("m_rdata", m_rdata, mem_rdata);
        void'(exp_q.pop_front());
        active = 0;
        done = 1;
      end else cnt--;
    end
    for (int i = 0; i < 2; i++) if (m_ready[i] && rem[i] > 0) rem[i]--;
    drive();
    req_pend = prev_done && |m_valid;
    prev_done = done;
  endtask
  task automatic run(input int max);
    for (int c = 0; c < max; c++) begin
      step();
      if (exp_q.size() == 0 && rem[0] == 0 && rem[1] == 0 && !mem_valid) return;
    end
    check("timeout", exp_q.size(), 0);
    exp_q.delete();
    rem[0] = 0;
    rem[1] = 0;
    drive();
  endtask
  task automatic gap(input int n);
    repeat (n) step();
  endtask
  initial begin
    setm(0, 32'h100, 32'h0, 4'h0, 0);
    setm(1, 32'h2000, 32'h0, 4'h0, 0);
    drive();
    mem_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_m_ready", m_ready, 0);
    check("rst_mem_addr", mem_addr, 32'h100);
    reset = 1;
    gap(2);
    setm(0, 32'h100, 32'h0, 4'h0, 1);
    push(0, 1);
    drive();
    run(20);
    gap(2);
    setm(0, 32'h104, 32'hAAAA5555, 4'hF, 4);
    setm(1, 32'h2004, 32'h0BADF00D, 4'hC, 4);
    for (int i = 0; i < 4; i++) begin
      push(1, 1);
      push(0, 1);
    end
    drive();
    run(60);
    gap(2);
    setm(1, 32'h2000, 32'h12345678, 4'h3, 1);
    wait_cfg = 3;
    push(1, 1);
    drive();
    run(30);
    wait_cfg = 0;
    gap(2);
    setm(0, 32'h300, 32'h0, 4'h0, 1);
    push(0, 1);
    drive();
    run(20);
    gap(2);
    setm(1, 32'h400, 32'h0, 4'h0, 1);
    wait_cfg = 5;
    push(1, 1);
    drive();
    repeat (3) step();
    reset = 0;
    rem[0] = 1;
    drive();
    mem_ready = 1;
    @(negedge clk);
    #1;
    check("midrst_mem_valid", mem_valid, 0);
    check("midrst_m_ready", m_ready, 0);
    check("midrst_mem_addr", mem_addr, 32'h300);
    reset = 1;
    exp_q.delete();
    active = 0;
    prev_done = 0;
    req_pend = 0;
    wait_cfg = 0;
    push(0, 1);
    push(1, 1);
    run(40);
`ifdef CACHE_ARB_BURST_LOCK_EN
    gap(2);
    setm(0, 32'h500, 32'h0, 4'h0, 10);
    setm(1, 32'h600, 32'h0, 4'h0, 2);
    push(0, 8);
    push(1, 2);
    push(0, 2);
    drive();
    run(100);
    gap(2);
    setm(0, 32'h700, 32'h0, 4'h0, 2);
    setm(1, 32'h800, 32'h0, 4'h0, 2);
    push(1, 2);
    push(0, 2);
    drive();
    run(40);
`endif
    gap(2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/iob_cache_be_arbiter.md
Name: iob_cache_be_arbiter

Overview:
- Shares one back-end native memory port between N_MASTERS native requesters, e.g. instruction-cache and data-cache back-ends in front of one external memory controller.
- Round-robin grant, held until the slave completes the transfer.
- One outstanding transaction at a time.
- Sits between the cache back-end native ports and the system memory interface.

Parameters:
- N_MASTERS, 2, number of requesting native masters (>=2).
- ADDR_W, 32, native address width.
- DATA_W, 32, native data width (multiple of 8).
- BURST_W, 3, log2 of the max locked read beats (burst-lock feature only).
- MASTER_W, $clog2(N_MASTERS), grant index width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
- m_valid  in  N_MASTERS  per-master request; master i at bit i.
- m_addr  in  N_MASTERS*ADDR_W  master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  master i at [i*DATA_W +: DATA_W].
- m_wstrb  in  N_MASTERS*DATA_W/8  master i slice; all-zero means read.
- m_rdata  out  DATA_W  mem_rdata broadcast to all masters.
- m_ready  out  N_MASTERS  per-master completion pulse.
- mem_valid  out  1  slave request.
- mem_addr  out  ADDR_W  granted master's address.
- mem_wdata  out  DATA_W  granted master's write data.
- mem_wstrb  out  DATA_W/8  granted master's strobes.
- mem_rdata  in  DATA_W  slave read data.
- mem_ready  in  1  slave completion.

Behaviour:
- Native protocol: a master holds valid/addr/wdata/wstrb stable until its ready pulse. The arbiter never drops a granted request.
- State machine has two states:
  - IDLE: mem_valid=0. If any m_valid is set, register the grant index per round-robin and go to BUSY. Else stay in IDLE.
  - BUSY: mem_valid=1. mem_addr/wdata/wstrb are muxed from the granted master. When mem_ready=1, go to IDLE.
- Round-robin:
  - Priority pointer ptr; search order ptr, ptr+1, ..., wrapping modulo N_MASTERS.
  - On each completion, ptr <= grant+1, wrapping from N_MASTERS-1 to 0.
- m_ready[i] = (state==BUSY) & (grant==i) & mem_ready. It is combinational, and exactly one bit is set per completion.
- m_rdata = mem_rdata, ungated. It is valid only when the matching m_ready bit is set.
- Latency:
  - Request seen in IDLE -> mem_valid asserted the next cycle.
  - Minimum 2 cycles per transaction.
  - One IDLE bubble between back-to-back transactions.
- mem_ready while in IDLE is ignored.
- A new request arriving in the same cycle as a completion is evaluated in the following IDLE cycle with the updated ptr.
- m_valid deassertion by the granted master while in BUSY is a protocol violation. The arbiter holds the grant regardless and mem_valid stays 1.
- Reset (reset==0 at a clock edge), including mid-transaction:
  - state=IDLE, grant=0, ptr=0, burst counter=0.
  - mem_valid=0 and m_ready=0 from the next cycle.
  - mem_addr/wdata/wstrb show master 0's inputs.
- Width rule: MASTER_W=1 when N_MASTERS=2. Pointer arithmetic wraps explicitly, so non-power-of-2 N_MASTERS is supported.

Optional Feature:
- Macro: CACHE_ARB_BURST_LOCK_EN. Supports cache-line refills, which are consecutive reads.
- Defined: a counter lock_cnt (BURST_W bits) is added.
  - On completion of a read (wstrb==0) by master g: if lock_cnt==0, load lock_cnt=2**BURST_W-1; otherwise decrement lock_cnt. ptr is not advanced while lock_cnt is non-zero after the update.
  - In IDLE, if lock_cnt!=0 and m_valid[g], re-grant g regardless of ptr.
  - If lock_cnt!=0 and g is not requesting, clear lock_cnt, advance ptr to g+1 and arbitrate normally in that same cycle.
  - A write completion clears lock_cnt and advances ptr normally.
  - Max consecutive locked reads = 2**BURST_W.
- Undefined: pure round-robin as above. The BURST_W parameter is unused.

Test Plan:
- Reset then single request: m_valid=2'b01, addr0=0x100, read, mem_ready one cycle after mem_valid -> mem_addr=0x100, m_ready=2'b01 for one cycle, m_rdata=mem_rdata=0xDEADBEEF, ptr=1.
- Contention: both masters request continuously, each transfer completes in 1 cycle -> grants alternate 0,1,0,1; mem_valid pattern 0,1,0,1.
- Write passthrough: master 1 wstrb=4'b0011, wdata=0x12345678, addr=0x2000 -> mem_wstrb=4'b0011, mem_wdata=0x12345678, mem_addr=0x2000 held stable until mem_ready; 3 wait cycles tolerated.
- Reset mid-transaction: reset=0 while BUSY with mem_ready=0 -> next cycle mem_valid=0, m_ready=0, and master 0 wins first after release even if ptr was 1.
- Burst lock (macro defined, BURST_W=3): master 0 issues 10 reads while master 1 requests -> master 0 gets 8 consecutive grants, then master 1 is granted.
- Burst lock early release: master 0 issues 2 reads then drops valid while master 1 requests -> master 1 granted in the IDLE cycle after master 0's 2nd completion.
